demux1x4_stripe: RTL and testbench

Single-clock 1-to-4 byte un-striping demultiplexer: the receive-side counterpart of the 4x1 lane-merging mux. It accepts one byte plus valid per clock and distributes consecutive valid bytes round-robin onto four lanes, lane 0 first. When the group is complete, all four lanes are presented in one registered beat with per-lane valid bits. It sits at the receive end of the PHY byte path and feeds the per-lane datapath.

---
 rtl/demux1x4_stripe.sv | 108 ++++++++++
 tb/tb_demux1x4_stripe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_stripe.sv
// rtl/demux1x4_stripe.sv - 1-to-4 byte un-striping demux; optional partial-group flush via DEMUX_IDLE_FLUSH_EN
module demux1x4_stripe #(
  parameter int WIDTH       = 8,
  parameter int IDLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             validin,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       validout,
  output logic [1:0]       lane_ptr
);

  typedef enum logic [1:0] {L0 = 2'd0, L1 = 2'd1, L2 = 2'd2, L3 = 2'd3} state_t;

  state_t           state;
  logic [WIDTH-1:0] stg0;
  logic [WIDTH-1:0] stg1;
  logic [WIDTH-1:0] stg2;

  // The idle threshold has to fit the 4-bit idle counter.
  if (IDLE_CYCLES < 1 || IDLE_CYCLES > 15) begin : g_idle_range_bad
    $error("IDLE_CYCLES must be in 1..15");
  end

  // The FSM state is the next lane to fill, so it is exported directly.
  assign lane_ptr = state;

`ifdef DEMUX_IDLE_FLUSH_EN
  logic [3:0] idle_cnt;
  logic       flush_now;

  // Flush on the edge where this idle cycle would bring the count to IDLE_CYCLES.
  assign flush_now = !validin && (state != L0) && (idle_cnt == 4'(IDLE_CYCLES - 1));
`endif

  // Lane FSM: stage bytes 0..2, emit the whole group when byte 3 arrives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= L0;
      stg0     <= '0;
      stg1     <= '0;
      stg2     <= '0;
      out0     <= '0;
      out1     <= '0;
      out2     <= '0;
      out3     <= '0;
      validout <= 4'b0000;
`ifdef DEMUX_IDLE_FLUSH_EN
      idle_cnt <= 4'd0;
`endif
    end else begin
      validout <= 4'b0000;
      if (validin) begin
`ifdef DEMUX_IDLE_FLUSH_EN
        idle_cnt <= 4'd0;
`endif
        case (state)
          L0: begin
            stg0  <= in;
            state <= L1;
          end
          L1: begin
            stg1  <= in;
            state <= L2;
          end
          L2: begin
            stg2  <= in;
            state <= L3;
          end
          L3: begin
            out0     <= stg0;
            out1     <= stg1;
            out2     <= stg2;
            out3     <= in;
            validout <= 4'b1111;
            state    <= L0;
          end
        endcase
      end
`ifdef DEMUX_IDLE_FLUSH_EN
      else if (state != L0) begin
        if (flush_now) begin
          // Partial group: filled lanes from staging, the rest forced to zero.
          out0     <= stg0;
          out1     <= (state == L2 || state == L3) ? stg1 : '0;
          out2     <= (state == L3) ? stg2 : '0;
          out3     <= '0;
          case (state)
            L1:      validout <= 4'b0001;
            L2:      validout <= 4'b0011;
            default: validout <= 4'b0111;
          endcase
          state    <= L0;
          idle_cnt <= 4'd0;
        end else begin
          idle_cnt <= idle_cnt + 4'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_demux1x4_stripe.sv
// tb/tb_demux1x4_stripe.sv - randomized self-checking bench for demux1x4_stripe (honours DEMUX_IDLE_FLUSH_EN)
module tb_demux1x4_stripe;

  localparam int WIDTH = 8;
  localparam int IDLE  = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             validin;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] out0, out1, out2, out3;
  logic [3:0]       validout;
  logic [1:0]       lane_ptr;
  logic [37:0]      act;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0] pending[$];
  logic [7:0] exp_out[4];
  logic [3:0] exp_vo;
  int         idle;
  int         emit_cyc[$];

  demux1x4_stripe #(.WIDTH(WIDTH), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .reset(reset), .in(din), .validin(validin),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .validout(validout), .lane_ptr(lane_ptr)
  );

  always #5 clk = ~clk;

  assign act = {out0, out1, out2, out3, validout, lane_ptr};

  function automatic logic [37:0] exp_vec();
    return {exp_out[0], exp_out[1], exp_out[2], exp_out[3], exp_vo, 2'(pending.size())};
  endfunction

  function automatic void model_reset();
    pending.delete();
    for (int i = 0; i < 4; i++) exp_out[i] = 8'h00;
    exp_vo = 4'b0000;
    idle   = 0;
  endfunction

  // Reference: bytes collect in a list; four bytes make a group, a long enough gap flushes a partial one.
  function automatic void model_edge(input logic v, input logic [7:0] d);
    exp_vo = 4'b0000;
    if (v) begin
      idle = 0;
      pending.push_back(d);
      if (pending.size() == 4) begin
        for (int i = 0; i < 4; i++) exp_out[i] = pending[i];
        exp_vo = 4'b1111;
        pending.delete();
      end
    end
`ifdef DEMUX_IDLE_FLUSH_EN
    else if (pending.size() != 0) begin
      idle++;
      if (idle == IDLE) begin
        for (int i = 0; i < 4; i++) exp_out[i] = (i < pending.size()) ? pending[i] : 8'h00;
        exp_vo = 4'((1 << pending.size()) - 1);
        pending.delete();
        idle = 0;
      end
    end
`endif
  endfunction

  task automatic step(input logic v, input logic [7:0] d);
    @(negedge clk);
    validin = v;
    din     = d;
    @(posedge clk);
    cyc++;
    model_edge(v, d);
    #1;
    if (validout !== 4'b0000) emit_cyc.push_back(cyc);
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    validin = 1'b0;
    din     = 8'h00;
    model_reset();
    repeat (3) begin
      @(posedge clk);
      #1;
      tests++;
      if (act !== 38'd0) begin
        fails++;
        $display("FAIL reset_hold act=%h exp=%h", act, 38'd0);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      step(1'b0, 8'h00);
      tests++;
      if (act !== 38'd0) begin
        fails++;
        $display("FAIL reset_idle act=%h exp=%h", act, 38'd0);
      end
    end
  endtask

  task automatic test_group();
    logic [7:0] b[4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i]);
      tests++;
      if (act !== exp_vec()) begin
        fails++;
        $display("FAIL group_byte%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    tests++;
    if (act !== {8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b1111, 2'd0}) begin
      fails++;
      $display("FAIL group_emit act=%h exp=%h", act, {8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b1111, 2'd0});
    end
    step(1'b0, 8'h00);
    tests++;
    if (act !== {8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0000, 2'd0}) begin
      fails++;
      $display("FAIL group_hold act=%h exp=%h", act, {8'hAA, 8'hBB, 8'hCC, 8'hDD, 4'b0000, 2'd0});
    end
  endtask

  task automatic test_gaps();
    logic [7:0] b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [1:0] ptr_seq[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      step(1'b1, b[i]);
      tests++;
      if (lane_ptr !== ptr_seq[i] || act !== exp_vec()) begin
        fails++;
        $display("FAIL gaps_byte%0d act=%h exp=%h", i, act, exp_vec());
      end
      if (i < 3) begin
        repeat (2) begin
          step(1'b0, 8'h5A);
          tests++;
          if (validout !== 4'b0000 || lane_ptr !== ptr_seq[i]) begin
            fails++;
            $display("FAIL gaps_idle%0d validout=%b lane_ptr=%0d exp 0000/%0d", i, validout, lane_ptr, ptr_seq[i]);
          end
        end
      end
    end
    tests++;
    if (act !== {8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 2'd0}) begin
      fails++;
      $display("FAIL gaps_emit act=%h exp=%h", act, {8'h11, 8'h22, 8'h33, 8'h44, 4'b1111, 2'd0});
    end
  endtask

  task automatic test_back_to_back();
    emit_cyc.delete();
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i));
      tests++;
      if (act !== exp_vec()) begin
        fails++;
        $display("FAIL b2b_byte%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    tests++;
    if (act !== {8'h05, 8'h06, 8'h07, 8'h08, 4'b1111, 2'd0}) begin
      fails++;
      $display("FAIL b2b_second act=%h exp=%h", act, {8'h05, 8'h06, 8'h07, 8'h08, 4'b1111, 2'd0});
    end
    tests++;
    if (emit_cyc.size() != 2 || emit_cyc[1] - emit_cyc[0] != 4) begin
      fails++;
      $display("FAIL b2b_spacing emissions=%0d spacing=%0d exp 2/4", emit_cyc.size(),
               (emit_cyc.size() == 2) ? emit_cyc[1] - emit_cyc[0] : -1);
    end
  endtask

  task automatic test_reset_mid_group();
    logic [7:0] f[4] = '{8'hF1, 8'hF2, 8'hF3, 8'hF4};
    step(1'b1, 8'hE1);
    step(1'b1, 8'hE2);
    @(negedge clk);
    validin = 1'b0;
    reset   = 1'b0;
    #1;
    model_reset();
    tests++;
    if (lane_ptr !== 2'd0 || validout !== 4'b0000) begin
      fails++;
      $display("FAIL midrst_async lane_ptr=%0d validout=%b exp 0/0000", lane_ptr, validout);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, f[i]);
      tests++;
      if (act !== exp_vec()) begin
        fails++;
        $display("FAIL midrst_byte%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
    tests++;
    if (act !== {8'hF1, 8'hF2, 8'hF3, 8'hF4, 4'b1111, 2'd0}) begin
      fails++;
      $display("FAIL midrst_emit act=%h exp=%h", act, {8'hF1, 8'hF2, 8'hF3, 8'hF4, 4'b1111, 2'd0});
    end
  endtask

  task automatic test_idle_flush();
    step(1'b1, 8'h5A);
    step(1'b1, 8'h5B);
`ifdef DEMUX_IDLE_FLUSH_EN
    for (int i = 1; i <= IDLE; i++) begin
      step(1'b0, 8'h00);
      tests++;
      if (i < IDLE && (validout !== 4'b0000 || lane_ptr !== 2'd2)) begin
        fails++;
        $display("FAIL flush_wait%0d validout=%b lane_ptr=%0d exp 0000/2", i, validout, lane_ptr);
      end else if (i == IDLE && act !== {8'h5A, 8'h5B, 8'h00, 8'h00, 4'b0011, 2'd0}) begin
        fails++;
        $display("FAIL flush_emit act=%h exp=%h", act, {8'h5A, 8'h5B, 8'h00, 8'h00, 4'b0011, 2'd0});
      end
    end
`else
    repeat (20) begin
      step(1'b0, 8'h00);
      tests++;
      if (validout !== 4'b0000 || lane_ptr !== 2'd2) begin
        fails++;
        $display("FAIL noflush_wait validout=%b lane_ptr=%0d exp 0000/2", validout, lane_ptr);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic v;
    int   gap_bias;
    for (int i = 0; i < 600; i++) begin
      gap_bias = (i % 100 < 50) ? 4 : 1;
      v = ($urandom_range(0, 9) >= gap_bias * 2);
      step(v, 8'($urandom));
      tests++;
      if (act !== exp_vec()) begin
        fails++;
        $display("FAIL random_cyc%0d act=%h exp=%h", i, act, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_group();
    test_gaps();
    test_back_to_back();
    test_reset_mid_group();
    test_idle_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
